// File: rtl/ibm1620_pkg.sv
// ============================================================================
// ibm1620_pkg - shared types and helpers for the 1620 SMS trigger models. Rev 1.0
// ============================================================================
`default_nettype none

package ibm1620_pkg;

    localparam int unsigned C_STAGES_DEF = 10;
    localparam int unsigned C_CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } ring_state_e;

    // Exactly one bit set; callers zero-extend narrower vectors to 32 bits.
    function automatic logic is_onehot32(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ibm1620_onehot_check.sv
// ============================================================================
// ibm1620_onehot_check - combinational WIDTH-bit one-hot detector. Rev 1.0
// ============================================================================
`default_nettype none

module ibm1620_onehot_check
    import ibm1620_pkg::*;
#(
    parameter int unsigned WIDTH = C_STAGES_DEF
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic             onehot_o
);

    logic [31:0] w_ext;

    assign w_ext    = 32'(vec_i);
    assign onehot_o = is_onehot32(w_ext);

endmodule

`default_nettype wire

// File: rtl/ibm1620_timing_ring.sv
// ============================================================================
// ibm1620_timing_ring - one-hot machine-cycle ring with cycle-boundary stop.
// Optional macro IBM1620_SINGLE_STEP_EN adds step_mode_i/step_i. Rev 1.0
// ============================================================================
`default_nettype none

module ibm1620_timing_ring
    import ibm1620_pkg::*;
#(
    parameter int unsigned STAGES = C_STAGES_DEF,
    parameter int unsigned CNT_W  = C_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              stop_i,
`ifdef IBM1620_SINGLE_STEP_EN
    input  logic              step_mode_i,
    input  logic              step_i,
`endif
    output logic              run_o,
    output logic [STAGES-1:0] phase_o,
    output logic              cycle_end_o,
    output logic [CNT_W-1:0]  cycle_count_o,
    output logic              ring_err_o
);

    localparam logic [STAGES-1:0] C_T0  = {{(STAGES-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ring_state_e       state_q, state_d;
    logic [STAGES-1:0] phase_q, phase_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              run_q, run_d;
    logic              cycle_end_q, cycle_end_d;
    logic              err_q, err_d;

    logic              w_onehot;
    logic              w_advance;
    logic              w_last;
    logic              w_running;

    ibm1620_onehot_check #(
        .WIDTH (STAGES)
    ) u_onehot (
        .vec_i    (phase_q),
        .onehot_o (w_onehot)
    );

`ifdef IBM1620_SINGLE_STEP_EN
    assign w_advance = !step_mode_i || step_i;
`else
    assign w_advance = 1'b1;
`endif

    assign w_last    = phase_q[STAGES-1];
    assign w_running = (state_q == ST_RUN) || (state_q == ST_STOPPING);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        count_d     = count_q;
        run_d       = run_q;
        cycle_end_d = 1'b0;
        err_d       = err_q | (w_running && !w_onehot);

        case (state_q)
            ST_IDLE: begin
                // A simultaneous stop overrides start.
                if (start_i && !stop_i) begin
                    state_d = ST_RUN;
                    phase_d = C_T0;
                    run_d   = 1'b1;
                end
            end
            ST_RUN, ST_STOPPING: begin
                if (w_advance) begin
                    if (w_last) begin
                        cycle_end_d = 1'b1;
                        count_d     = count_q + C_ONE;
                        if ((state_q == ST_STOPPING) || stop_i) begin
                            state_d = ST_IDLE;
                            phase_d = '0;
                            run_d   = 1'b0;
                        end else begin
                            phase_d = C_T0;
                        end
                    end else begin
                        phase_d = {phase_q[STAGES-2:0], phase_q[STAGES-1]};
                        if (stop_i) begin
                            state_d = ST_STOPPING;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
                run_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            count_q     <= '0;
            run_q       <= 1'b0;
            cycle_end_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            count_q     <= count_d;
            run_q       <= run_d;
            cycle_end_q <= cycle_end_d;
            err_q       <= err_d;
        end
    end

    assign run_o         = run_q;
    assign phase_o       = phase_q;
    assign cycle_end_o   = cycle_end_q;
    assign cycle_count_o = count_q;
    assign ring_err_o    = err_q;

endmodule

`default_nettype wire

// File: doc/ibm1620_timing_ring.md
# ibm1620_timing_ring

Parametrised N-stage timing ring for the 1620 SMS card models. It replaces the fixed oscillator-plus-trigger card pair with one clocked block. The ring produces one-hot machine-cycle phases (T0..T(N-1)), a cycle-end strobe and a wrapping cycle counter. It also has a start/stop handshake that always halts on a cycle boundary, and it sits between the clock source and the core control logic.

## Interface
- STAGES, 10: number of ring stages, 2..32.
- CNT_W, 16: width of the cycle counter.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level-sampled request to begin cycling; acted on only in IDLE.
- stop  in  1  level-sampled request to halt at the next cycle boundary.
- run  out  1  high while the ring is cycling (RUN or STOPPING).
- phase  out  STAGES  one-hot stage vector; all-zero when idle.
- cycle_end  out  1  one-clock pulse on the clock where the ring leaves stage STAGES-1.
- cycle_count  out  CNT_W  number of completed cycles, modulo 2^CNT_W.
- ring_err  out  1  sticky flag: phase was not one-hot while running.

## Operation
- States:
  - IDLE: ring stopped.
  - RUN: cycling.
  - STOPPING: cycling with a stop pending.
- Transitions:
  - IDLE: start=1 and stop=0 → RUN, phase=1 (T0) on the same edge. start=1 and stop=1 together → stay in IDLE (stop wins).
  - RUN: phase rotates left one stage per clock, with T(N-1) wrapping to T0. stop=1 → STOPPING; rotation continues.
  - RUN or STOPPING at stage N-1: if stop is pending (STOPPING, or stop=1 on this clock), go to IDLE with phase=0. Otherwise go to T0.
  - start has no effect outside IDLE. stop has no effect in IDLE.
- Cycle completion:
  - Every departure from stage N-1 pulses cycle_end, including the stopping departure.
  - The same edge increments cycle_count, wrapping from 2^CNT_W-1 to 0.
- Checker:
  - Each clock in RUN or STOPPING, phase is tested for one-hot.
  - A failure sets ring_err, which holds until reset.
  - The state machine does not act on ring_err.
- Reset mid-cycle: all outputs clear immediately and asynchronously. No partial cycle is counted.

## Timing
- Reset values: run=0, phase=0, cycle_end=0, cycle_count=0, ring_err=0. State is IDLE.
- start → T0 latency: one clock. run rises on the same edge.
- Cycle length: exactly STAGES clocks per cycle.
- Stop latency: ring stops at the first stage N-1 departure at or after the stop sample. The worst case is STAGES clocks.
- After halting, a new start is accepted no earlier than the next clock.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- IBM1620_SINGLE_STEP_EN defined:
  - Adds inputs step_mode (1) and step (1).
  - While step_mode=1, the ring advances only on clocks where step=1. Otherwise phase, state and counters hold.
  - The start/stop rules are unchanged. A start in IDLE still loads T0 without needing a step.
  - A stop halts only when a step moves the ring out of stage N-1.
- Not defined:
  - The ports are absent.
  - The ring advances every clock, as described above.

## Structure
- Shared package ibm1620_pkg holds:
  - the ring-state enum (IDLE, RUN, STOPPING);
  - the default STAGES/CNT_W constants;
  - a one-hot check function shared with other SMS trigger models.
- One sub-module: ibm1620_onehot_check, combinational STAGES-wide one-hot detect. The top registers its sticky result.

## Test plan
- Start and run: reset, start=1 for one clock, STAGES=10 → phase 0x001, 0x002, … 0x200, 0x001. cycle_end pulses every 10th clock, and cycle_count=3 after 30 clocks.
- Stop mid-cycle: stop=1 at T4 → phase continues to T9, then phase=0 and run=0 on the next edge. One cycle_end pulse at the halt; cycle_count incremented once.
- Start and stop together in IDLE → run stays 0 and phase stays 0. A later start alone starts the ring.
- Counter wrap: CNT_W=2, run 5 cycles → cycle_count sequence 1, 2, 3, 0, 1.
- Reset at T6 with run=1 → all outputs 0 asynchronously, before the next clock edge. The next start gives T0.
- With IBM1620_SINGLE_STEP_EN, step_mode=1: 3 step pulses spread over 20 clocks after start → phase=T3. Phase and counters hold between pulses.
